// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch resolution, destination select, an iterative
// shift-add multiplier feeding HI/LO, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_a,
  input  logic [DATA_W-1:0] ex_b,
  input  logic [DATA_W-1:0] ex_imm,
  input  logic [DATA_W-1:0] ex_pc4,
  input  logic [4:0]        ex_rt,
  input  logic [4:0]        ex_rd,
  input  logic [5:0]        ex_funct,
  input  logic [2:0]        ex_alu_op,
  input  logic              ex_reg_dst,
  input  logic              ex_alu_src,
  input  logic              ex_branch,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  output logic              stall_o,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [4:0]        mem_wreg,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              mem_reg_write,
  output logic              mem_br_taken,
  output logic [DATA_W-1:0] mem_br_target
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ANDI  = 3'b011;
  localparam logic [2:0] ALU_ORI   = 3'b100;
  localparam logic [2:0] ALU_SLTI  = 3'b101;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                start_s;
  logic                load_s;
  logic                mul_last_s;

  logic [DATA_W-1:0]   op_b_s;
  logic                lt_s;
  logic [DATA_W-1:0]   slt_word_s;
  logic [DATA_W-1:0]   rtype_result_s;
  logic [DATA_W-1:0]   alu_result_s;
  logic                is_mult_s;
  logic [4:0]          wreg_s;
  logic                br_taken_s;
  logic [DATA_W-1:0]   br_target_s;

  logic [DATA_W-1:0]   mcand_r;
  logic [DATA_W-1:0]   mplier_r;
  // Bit 0 of the accumulator is provably zero until the final step, so it is not stored.
  logic [2*DATA_W-1:1] acc_r;
  logic [DATA_W:0]     partial_sum_s;
  logic [2*DATA_W-1:0] acc_step_s;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;

  // Operand selection, signed compare and branch resolution
  always_comb begin
    op_b_s      = ex_alu_src ? ex_imm : ex_b;
    lt_s        = ($signed(ex_a) < $signed(op_b_s));
    slt_word_s  = {{(DATA_W-1){1'b0}}, lt_s};
    wreg_s      = ex_reg_dst ? ex_rd : ex_rt;
    br_taken_s  = ex_branch && (ex_a == ex_b);
    br_target_s = ex_pc4 + (ex_imm << 2'd2);
    is_mult_s   = in_valid && !flush && (ex_alu_op == ALU_RTYPE) && (ex_funct == F_MULT);
  end

  // R-type result by funct; unknown funct yields zero
  always_comb begin
    rtype_result_s = '0;
    case (ex_funct)
      F_ADD:   rtype_result_s = ex_a + op_b_s;
      F_SUB:   rtype_result_s = ex_a - op_b_s;
      F_AND:   rtype_result_s = ex_a & op_b_s;
      F_OR:    rtype_result_s = ex_a | op_b_s;
      F_SLT:   rtype_result_s = slt_word_s;
      F_MFHI:  rtype_result_s = hi_r;
      F_MFLO:  rtype_result_s = lo_r;
      F_MULT:  rtype_result_s = '0;
      default: rtype_result_s = '0;
    endcase
  end

  // Main ALU result by alu_op
  always_comb begin
    alu_result_s = '0;
    case (ex_alu_op)
      ALU_ADD:   alu_result_s = ex_a + op_b_s;
      ALU_SUB:   alu_result_s = ex_a - op_b_s;
      ALU_RTYPE: alu_result_s = rtype_result_s;
      ALU_ANDI:  alu_result_s = ex_a & op_b_s;
      ALU_ORI:   alu_result_s = ex_a | op_b_s;
      ALU_SLTI:  alu_result_s = slt_word_s;
      default:   alu_result_s = ex_a + op_b_s;
    endcase
  end

  // Multiplier FSM next state, stall and EX/MEM load enable
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_o     = 1'b0;
    load_s      = 1'b0;
    start_s     = 1'b0;
    mul_last_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (is_mult_s) begin
          start_s     = 1'b1;
          stall_o     = 1'b1;
          state_nxt_s = S_MUL;
          cnt_nxt_s   = '0;
        end else begin
          load_s = in_valid && !flush;
        end
      end
      S_MUL: begin
        // Stall drops in the last cycle so the next instruction arrives as HI/LO commit.
        if (cnt_r == CNT_LAST) begin
          mul_last_s  = 1'b1;
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = '0;
        end else begin
          stall_o   = 1'b1;
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // One shift-add step: conditional add into the high half, then shift right
  always_comb begin
    partial_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]} +
                    (mplier_r[0] ? {1'b0, mcand_r} : {(DATA_W+1){1'b0}});
    acc_step_s    = {partial_sum_s, acc_r[DATA_W-1:1]};
  end

  // FSM state and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Multiplier operands, accumulator and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else if (start_s) begin
      mcand_r  <= ex_a;
      mplier_r <= ex_b;
      acc_r    <= '0;
    end else if (state_r == S_MUL) begin
      acc_r    <= acc_step_s[2*DATA_W-1:1];
      mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
      if (mul_last_s) begin
        hi_r <= acc_step_s[2*DATA_W-1:DATA_W];
        lo_r <= acc_step_s[DATA_W-1:0];
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end else begin
      acc_r    <= acc_r;
      mplier_r <= mplier_r;
    end
  end

  // EX/MEM register: controls are gated to zero for bubbles, data is held
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_wreg       <= 5'd0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_br_taken   <= 1'b0;
      mem_br_target  <= '0;
    end else begin
      mem_valid      <= load_s;
      mem_mem_read   <= load_s && ex_mem_read;
      mem_mem_write  <= load_s && ex_mem_write;
      mem_mem_to_reg <= load_s && ex_mem_to_reg;
      mem_reg_write  <= load_s && ex_reg_write;
      mem_br_taken   <= load_s && br_taken_s;
      if (load_s) begin
        mem_alu_result <= alu_result_s;
        mem_store_data <= ex_b;
        mem_wreg       <= wreg_s;
        mem_br_target  <= br_target_s;
      end else begin
        mem_alu_result <= mem_alu_result;
        mem_store_data <= mem_store_data;
        mem_wreg       <= mem_wreg;
        mem_br_target  <= mem_br_target;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a cycle-level reference model queues expected
// EX/MEM entries and stall values; a monitor pops and compares them.
module tb_ex_stage;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst, in_valid, flush;
  logic [W-1:0] ex_a, ex_b, ex_imm, ex_pc4;
  logic [4:0] ex_rt, ex_rd;
  logic [5:0] ex_funct;
  logic [2:0] ex_alu_op;
  logic ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic stall_o, mem_valid;
  logic [W-1:0] mem_alu_result, mem_store_data, mem_br_target;
  logic [4:0] mem_wreg;
  logic mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_br_taken;

  ex_stage #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_alu_op(ex_alu_op),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .stall_o(stall_o), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_wreg(mem_wreg),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
    .mem_br_taken(mem_br_taken), .mem_br_target(mem_br_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          valid;
    bit          full;
    logic [31:0] res, sdata, tgt;
    logic [4:0]  wreg;
    bit          mr, mw, m2r, rw, bt;
  } exp_t;
  typedef struct {
    int due;
    bit stall;
  } st_t;

  exp_t exq[$];
  st_t  stq[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int vcount = 0;
  bit known = 1'b0;

  // Reference model state: architectural HI/LO, pending product, cycles left busy
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  int busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_alu(logic [2:0] op, logic [5:0] fn, logic [31:0] a,
                                          logic [31:0] bop);
    logic [31:0] slt;
    slt = ($signed(a) < $signed(bop)) ? 32'd1 : 32'd0;
    case (op)
      3'd1: return a - bop;
      3'd2: begin
        case (fn)
          6'h20: return a + bop;
          6'h22: return a - bop;
          6'h24: return a & bop;
          6'h25: return a | bop;
          6'h2A: return slt;
          6'h10: return m_hi;
          6'h12: return m_lo;
          default: return 32'd0;
        endcase
      end
      3'd3: return a & bop;
      3'd4: return a | bop;
      3'd5: return slt;
      default: return a + bop;
    endcase
  endfunction

  task automatic model_step();
    exp_t e;
    st_t s;
    bit is_mult;
    logic [63:0] prod;
    is_mult = in_valid && !flush && ex_alu_op == 3'd2 && ex_funct == 6'h18;
    s.due = cyc;
    s.stall = (busy > 0) ? (busy > 1) : is_mult;
    if (known) stq.push_back(s);
    e.due = cyc + 1; e.valid = 0; e.full = 0;
    e.res = 0; e.sdata = 0; e.tgt = 0; e.wreg = 0;
    e.mr = 0; e.mw = 0; e.m2r = 0; e.rw = 0; e.bt = 0;
    if (rst) begin
      e.full = 1; m_hi = 0; m_lo = 0; busy = 0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (is_mult) begin
      prod = {32'd0, ex_a} * {32'd0, ex_b};
      p_hi = prod[63:32]; p_lo = prod[31:0];
      busy = W;
    end else if (in_valid && !flush) begin
      e.valid = 1; e.full = 1;
      e.res   = ref_alu(ex_alu_op, ex_funct, ex_a, ex_alu_src ? ex_imm : ex_b);
      e.sdata = ex_b;
      e.wreg  = ex_reg_dst ? ex_rd : ex_rt;
      e.tgt   = ex_pc4 + ex_imm * 32'd4;
      e.bt    = ex_branch && (ex_a == ex_b);
      e.mr = ex_mem_read; e.mw = ex_mem_write; e.m2r = ex_mem_to_reg; e.rw = ex_reg_write;
    end
    exq.push_back(e);
  endtask

  // Monitor: compares queued expectations against the DUT on the falling edge
  initial begin
    exp_t e;
    st_t s;
    forever begin
      @(negedge clk);
      while (stq.size() > 0 && stq[0].due <= cyc) begin
        s = stq.pop_front();
        chk("stall_o", {31'd0, stall_o}, {31'd0, s.stall});
      end
      while (exq.size() > 0 && exq[0].due <= cyc) begin
        e = exq.pop_front();
        chk("mem_valid", {31'd0, mem_valid}, {31'd0, e.valid});
        chk("mem_mem_read", {31'd0, mem_mem_read}, {31'd0, e.mr});
        chk("mem_mem_write", {31'd0, mem_mem_write}, {31'd0, e.mw});
        chk("mem_mem_to_reg", {31'd0, mem_mem_to_reg}, {31'd0, e.m2r});
        chk("mem_reg_write", {31'd0, mem_reg_write}, {31'd0, e.rw});
        chk("mem_br_taken", {31'd0, mem_br_taken}, {31'd0, e.bt});
        if (e.full) begin
          chk("mem_alu_result", mem_alu_result, e.res);
          chk("mem_store_data", mem_store_data, e.sdata);
          chk("mem_wreg", {27'd0, mem_wreg}, {27'd0, e.wreg});
          chk("mem_br_target", mem_br_target, e.tgt);
        end
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (mem_valid) vcount++;
  endtask

  task automatic clear_in();
    in_valid = 0; flush = 0; ex_a = 0; ex_b = 0; ex_imm = 0; ex_pc4 = 0;
    ex_rt = 0; ex_rd = 0; ex_funct = 0; ex_alu_op = 0; ex_reg_dst = 0; ex_alu_src = 0;
    ex_branch = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0; ex_reg_write = 0;
  endtask

  task automatic set_r(logic [5:0] fn, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    clear_in();
    in_valid = 1; ex_alu_op = 3'd2; ex_funct = fn; ex_a = a; ex_b = b;
    ex_reg_dst = 1; ex_rd = rd; ex_reg_write = (fn != 6'h18);
  endtask

  task automatic set_i(logic [2:0] op, logic [31:0] a, logic [31:0] imm, logic [4:0] rt);
    clear_in();
    in_valid = 1; ex_alu_op = op; ex_a = a; ex_imm = imm; ex_alu_src = 1;
    ex_rt = rt; ex_reg_write = 1;
  endtask

  // Holds a mult in ID/EX until stall_o drops; returns number of stalled cycles
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, output int nst);
    bit st;
    nst = 0;
    set_r(6'h18, a, b, 5'd0);
    for (int k = 0; k < 4 * W; k++) begin
      #1;
      st = stall_o;
      tick();
      if (st) nst++;
      else break;
    end
  endtask

  initial begin
    int nst;
    int v0;
    clear_in();
    rst = 1;
    @(posedge clk);
    #1;
    known = 1;
    tick();
    rst = 0;

    // add 5+7 -> rd 3
    set_r(6'h20, 32'd5, 32'd7, 5'd3);
    tick();
    chk("t1_add_result", mem_alu_result, 32'd12);
    chk("t1_add_wreg", {27'd0, mem_wreg}, 32'd3);
    chk("t1_add_valid", {31'd0, mem_valid}, 32'd1);

    ex_alu_op = 3'd1; ex_a = 32'd0; ex_b = 32'd1; ex_funct = 6'h00;
    tick();
    chk("t2_sub", mem_alu_result, 32'hFFFFFFFF);
    set_r(6'h2A, 32'hFFFFFFFF, 32'd1, 5'd4);
    tick();
    chk("t2_slt", mem_alu_result, 32'd1);
    set_i(3'd5, 32'd1, 32'hFFFFFFFF, 5'd5);
    tick();
    chk("t2_slti", mem_alu_result, 32'd0);
    set_i(3'd3, 32'h0000F0F0, 32'h00000FF0, 5'd6);
    tick();
    chk("t2_andi", mem_alu_result, 32'h000000F0);

    // beq taken / not taken
    clear_in();
    in_valid = 1; ex_alu_op = 3'd1; ex_branch = 1; ex_a = 32'd9; ex_b = 32'd9;
    ex_pc4 = 32'd100; ex_imm = 32'hFFFFFFFE;
    tick();
    chk("t3_beq_taken", {31'd0, mem_br_taken}, 32'd1);
    chk("t3_beq_target", mem_br_target, 32'd92);
    ex_b = 32'd8;
    tick();
    chk("t3_beq_not_taken", {31'd0, mem_br_taken}, 32'd0);

    // mult FFFFFFFF*2, then mfhi, mflo
    v0 = vcount;
    run_mult(32'hFFFFFFFF, 32'd2, nst);
    chk("t4_stall_cycles", nst, 32'd32);
    set_r(6'h10, 32'd0, 32'd0, 5'd8);
    tick();
    chk("t4_mfhi", mem_alu_result, 32'd1);
    set_r(6'h12, 32'd0, 32'd0, 5'd9);
    tick();
    chk("t4_mflo", mem_alu_result, 32'hFFFFFFFE);
    chk("t4_valid_entries", vcount - v0, 32'd2);

    // flushed mult does nothing
    set_r(6'h18, 32'd3, 32'd4, 5'd0);
    flush = 1;
    #1;
    chk("t5_flush_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("t5_flush_bubble", {31'd0, mem_valid}, 32'd0);
    set_r(6'h10, 32'd0, 32'd0, 5'd8);
    tick();
    chk("t5_hi_kept", mem_alu_result, 32'd1);

    // reset in the middle of a multiply
    set_r(6'h18, 32'd3, 32'd4, 5'd0);
    tick();
    repeat (10) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t5_rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("t5_rst_result", mem_alu_result, 32'd0);
    clear_in();
    #1;
    chk("t5_rst_stall", {31'd0, stall_o}, 32'd0);
    set_r(6'h10, 32'd0, 32'd0, 5'd8);
    tick();
    chk("t5_rst_hi", mem_alu_result, 32'd0);
    set_r(6'h12, 32'd0, 32'd0, 5'd9);
    tick();
    chk("t5_rst_lo", mem_alu_result, 32'd0);

    // back-to-back multiplies
    run_mult(32'd6, 32'd7, nst);
    run_mult(32'd2, 32'd3, nst);
    chk("t6_second_stall", nst, 32'd32);
    set_r(6'h12, 32'd0, 32'd0, 5'd9);
    tick();
    chk("t6_lo", mem_alu_result, 32'd6);
    set_r(6'h10, 32'd0, 32'd0, 5'd8);
    tick();
    chk("t6_hi", mem_alu_result, 32'd0);
    clear_in();
    tick();
    chk("t6_bubble", {31'd0, mem_valid}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(199, 0) == 0);
      in_valid = ($urandom_range(3, 0) != 0);
      flush = ($urandom_range(9, 0) == 0);
      ex_a = $urandom;
      ex_b = ($urandom_range(3, 0) == 0) ? ex_a : $urandom;
      ex_imm = $urandom;
      ex_pc4 = $urandom;
      ex_rt = 5'($urandom); ex_rd = 5'($urandom);
      ex_alu_op = 3'($urandom);
      case ($urandom_range(9, 0))
        0: ex_funct = 6'h18;
        1: ex_funct = 6'h10;
        2: ex_funct = 6'h12;
        3: ex_funct = 6'h20;
        4: ex_funct = 6'h22;
        5: ex_funct = 6'h24;
        6: ex_funct = 6'h25;
        7: ex_funct = 6'h2A;
        default: ex_funct = 6'($urandom);
      endcase
      {ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read} = 4'($urandom);
      {ex_mem_write, ex_mem_to_reg, ex_reg_write} = 3'($urandom);
      tick();
    end
    rst = 0;
    clear_in();
    tick();

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
